// File: rtl/axis_frame_gen.sv
// axis_frame_gen
// Builds one AXI-Stream frame per accepted command and drives it to a
// downstream sink. The payload is seed, seed+1, ... (wrapping at the data
// width). The last beat carries tlast, and it carries tuser when the command
// was flagged bad.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   cmd_*                command channel (valid/ready, len, id, dest, seed, bad)
//   m_axis_*             AXI-Stream master output (tkeep always all ones)
//   status_busy          high whenever the generator is not idle
//   status_frame_done    one-cycle pulse per completed (or zero-length) command
//   status_len_error     one-cycle pulse per zero-length command
//   status_frame_count   completed frames, wraps modulo 2^32
module axis_frame_gen #(
    parameter int                    DATA_WIDTH           = 8,
    parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int                    ID_WIDTH             = 8,
    parameter int                    DEST_WIDTH           = 8,
    parameter int                    USER_WIDTH           = 1,
    parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
    parameter int                    LEN_WIDTH            = 16,
    parameter int                    IFG_CYCLES           = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DEST_WIDTH-1:0] cmd_dest,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    input  logic                  cmd_bad,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_busy,
    output logic                  status_frame_done,
    output logic                  status_len_error,
    output logic [31:0]           status_frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [15:0]           GAP_LAST  = 16'((IFG_CYCLES > 0) ? (IFG_CYCLES - 1) : 0);
    localparam logic [USER_WIDTH-1:0] USER_GOOD = {USER_WIDTH{1'b0}};

    state_t                state_r, state_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic [LEN_WIDTH-1:0]  beat_cnt_r, beat_cnt_s;
    logic [DATA_WIDTH-1:0] seed_r, seed_s;
    logic                  bad_r, bad_s;
    logic [15:0]           gap_cnt_r, gap_cnt_s;
    logic [DATA_WIDTH-1:0] tdata_r, tdata_s;
    logic                  tvalid_r, tvalid_s;
    logic                  tlast_r, tlast_s;
    logic [ID_WIDTH-1:0]   tid_r, tid_s;
    logic [DEST_WIDTH-1:0] tdest_r, tdest_s;
    logic [USER_WIDTH-1:0] tuser_r, tuser_s;
    logic                  cmd_ready_r, cmd_ready_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  len_err_r, len_err_s;
    logic [31:0]           count_r, count_s;

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        beat_cnt_s  = beat_cnt_r;
        seed_s      = seed_r;
        bad_s       = bad_r;
        gap_cnt_s   = gap_cnt_r;
        tdata_s     = tdata_r;
        tvalid_s    = tvalid_r;
        tlast_s     = tlast_r;
        tid_s       = tid_r;
        tdest_s     = tdest_r;
        tuser_s     = tuser_r;
        cmd_ready_s = cmd_ready_r;
        done_s      = 1'b0;
        len_err_s   = 1'b0;
        count_s     = count_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    if (cmd_len == LEN_ZERO) begin
                        // Nothing to send: report and stay ready for the next command.
                        done_s    = 1'b1;
                        len_err_s = 1'b1;
                    end else begin
                        // Load the first beat directly so it appears the cycle after accept.
                        state_s     = ST_SEND;
                        len_s       = cmd_len;
                        seed_s      = cmd_seed;
                        bad_s       = cmd_bad;
                        beat_cnt_s  = LEN_ZERO;
                        tvalid_s    = 1'b1;
                        tdata_s     = cmd_seed;
                        tlast_s     = (cmd_len == LEN_ONE);
                        tuser_s     = ((cmd_len == LEN_ONE) && cmd_bad) ? USER_BAD_FRAME_VALUE : USER_GOOD;
                        tid_s       = cmd_id;
                        tdest_s     = cmd_dest;
                        cmd_ready_s = 1'b0;
                    end
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            ST_SEND: begin
                if (tvalid_r && m_axis_tready) begin
                    if (tlast_r) begin
                        tvalid_s = 1'b0;
                        tlast_s  = 1'b0;
                        tuser_s  = USER_GOOD;
                        done_s   = 1'b1;
                        count_s  = count_r + 32'd1;
                        if (IFG_CYCLES > 0) begin
                            state_s   = ST_GAP;
                            gap_cnt_s = 16'd0;
                        end else begin
                            state_s     = ST_IDLE;
                            cmd_ready_s = 1'b1;
                        end
                    end else begin
                        // Precompute the following beat from the advanced counter.
                        beat_cnt_s = beat_cnt_r + LEN_ONE;
                        tdata_s    = seed_r + DATA_WIDTH'(beat_cnt_s);
                        tlast_s    = (beat_cnt_s == (len_r - LEN_ONE));
                        tuser_s    = ((beat_cnt_s == (len_r - LEN_ONE)) && bad_r) ? USER_BAD_FRAME_VALUE : USER_GOOD;
                    end
                end else begin
                    tvalid_s = tvalid_r;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s     = ST_IDLE;
                    cmd_ready_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + 16'd1;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                tvalid_s    = 1'b0;
                tlast_s     = 1'b0;
                tuser_s     = USER_GOOD;
                cmd_ready_s = 1'b1;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            len_r       <= LEN_ZERO;
            beat_cnt_r  <= LEN_ZERO;
            seed_r      <= {DATA_WIDTH{1'b0}};
            bad_r       <= 1'b0;
            gap_cnt_r   <= 16'd0;
            tdata_r     <= {DATA_WIDTH{1'b0}};
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tid_r       <= {ID_WIDTH{1'b0}};
            tdest_r     <= {DEST_WIDTH{1'b0}};
            tuser_r     <= USER_GOOD;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            len_err_r   <= 1'b0;
            count_r     <= 32'd0;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            beat_cnt_r  <= beat_cnt_s;
            seed_r      <= seed_s;
            bad_r       <= bad_s;
            gap_cnt_r   <= gap_cnt_s;
            tdata_r     <= tdata_s;
            tvalid_r    <= tvalid_s;
            tlast_r     <= tlast_s;
            tid_r       <= tid_s;
            tdest_r     <= tdest_s;
            tuser_r     <= tuser_s;
            cmd_ready_r <= cmd_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            len_err_r   <= len_err_s;
            count_r     <= count_s;
        end
    end

    assign cmd_ready          = cmd_ready_r;
    assign m_axis_tdata       = tdata_r;
    assign m_axis_tkeep       = {KEEP_WIDTH{1'b1}};
    assign m_axis_tvalid      = tvalid_r;
    assign m_axis_tlast       = tlast_r;
    assign m_axis_tid         = tid_r;
    assign m_axis_tdest       = tdest_r;
    assign m_axis_tuser       = tuser_r;
    assign status_busy        = busy_r;
    assign status_frame_done  = done_r;
    assign status_len_error   = len_err_r;
    assign status_frame_count = count_r;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Testbench for axis_frame_gen: directed scenarios plus randomized frames with
// random sink backpressure. The expected beat stream comes from a queue of
// beats computed from each command. A second instance with a 3-cycle
// inter-frame gap checks the gap timing.
module tb_axis_frame_gen;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic [7:0] id;
        logic [7:0] dest;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // main instance (no inter-frame gap)
    logic        cmd_valid = 1'b0, cmd_ready, cmd_bad = 1'b0;
    logic [15:0] cmd_len = 16'd0;
    logic [7:0]  cmd_id = 8'd0, cmd_dest = 8'd0, cmd_seed = 8'd0;
    logic [7:0]  tdata, tid, tdest;
    logic [0:0]  tkeep, tuser;
    logic        tvalid, tready = 1'b1, tlast;
    logic        busy, done, len_err;
    logic [31:0] count;

    // gap instance
    logic        cmd_valid_g = 1'b0, cmd_ready_g, cmd_bad_g = 1'b0;
    logic [15:0] cmd_len_g = 16'd0;
    logic [7:0]  cmd_id_g = 8'd0, cmd_dest_g = 8'd0, cmd_seed_g = 8'd0;
    logic [7:0]  tdata_g, tid_g, tdest_g;
    logic [0:0]  tkeep_g, tuser_g;
    logic        tvalid_g, tlast_g;
    logic        tready_g = 1'b1;
    logic        busy_g, done_g, len_err_g;
    logic [31:0] count_g;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    int          exp_count = 0;
    logic        done_exp = 1'b0;
    logic        lenerr_exp = 1'b0;
    int          hs_count = 0;
    logic        stall_q = 1'b0;
    logic [63:0] prev_q = 64'd0;
    bit          tready_rand = 1'b0;

    axis_frame_gen dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .cmd_id(cmd_id), .cmd_dest(cmd_dest), .cmd_seed(cmd_seed), .cmd_bad(cmd_bad),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tid(tid),
        .m_axis_tdest(tdest), .m_axis_tuser(tuser),
        .status_busy(busy), .status_frame_done(done),
        .status_len_error(len_err), .status_frame_count(count)
    );

    axis_frame_gen #(.IFG_CYCLES(3)) dut_gap (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_g), .cmd_ready(cmd_ready_g), .cmd_len(cmd_len_g),
        .cmd_id(cmd_id_g), .cmd_dest(cmd_dest_g), .cmd_seed(cmd_seed_g), .cmd_bad(cmd_bad_g),
        .m_axis_tdata(tdata_g), .m_axis_tkeep(tkeep_g), .m_axis_tvalid(tvalid_g),
        .m_axis_tready(tready_g), .m_axis_tlast(tlast_g), .m_axis_tid(tid_g),
        .m_axis_tdest(tdest_g), .m_axis_tuser(tuser_g),
        .status_busy(busy_g), .status_frame_done(done_g),
        .status_len_error(len_err_g), .status_frame_count(count_g)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Random sink backpressure, only while enabled.
    always @(posedge clk) begin
        #2;
        if (tready_rand) tready = 1'($urandom_range(0, 1));
    end

    // Stream monitor: stability under stall, beat-by-beat comparison, status pulses.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            chk("frame_done", done, done_exp);
            chk("len_error", len_err, lenerr_exp);
            chk("frame_count", count, exp_count);
            chk("tkeep", tkeep, 64'd1);
            done_exp   = 1'b0;
            lenerr_exp = 1'b0;
            if (stall_q)
                chk("stable_under_stall", {tvalid, tdata, tlast, tuser, tid, tdest}, prev_q);
            if (tvalid && tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", tvalid, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {tdata, tlast, tuser, tid, tdest}, e);
                    if (e.last) begin
                        exp_count++;
                        done_exp = 1'b1;
                    end
                end
            end else if (tvalid && exp_q.size() == 0) begin
                chk("unexpected_valid", tvalid, 64'd0);
            end
            stall_q = tvalid && !tready;
            prev_q  = {tvalid, tdata, tlast, tuser, tid, tdest};
        end
    end

    // Offer one command (called just after a rising edge) and record its beats.
    task automatic send_cmd(input int len, input logic [7:0] seed, input logic [7:0] id,
                            input logic [7:0] dest, input logic bad);
        cmd_len   = 16'(len);
        cmd_seed  = seed;
        cmd_id    = id;
        cmd_dest  = dest;
        cmd_bad   = bad;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (len == 0) begin
            done_exp   = 1'b1;
            lenerr_exp = 1'b1;
        end else begin
            for (int i = 0; i < len; i++) begin
                beat_t b;
                b.data = 8'(seed + i);
                b.last = (i == len - 1);
                b.user = bad && (i == len - 1);
                b.id   = id;
                b.dest = dest;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", ok, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  acc;
        int  last1;
        int  first2;
        bit  v[30];
        bit  r[30];
        bit  l[30];
        logic [7:0] d[30];

        // reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {tvalid, tlast, tuser, tdata, tid, tdest}, 64'd0);
        chk("rst_cmd_ready", cmd_ready, 64'd1);
        chk("rst_status", {busy, done, len_err}, 64'd0);
        chk("rst_count", count, 64'd0);
        @(posedge clk);
        #1;

        // basic frame with latency and back-to-back readiness
        tready = 1'b1;
        send_cmd(4, 8'h10, 8'd3, 8'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("basic_tvalid", tvalid, 64'd1);
            if (i == 0) chk("basic_busy", busy, 64'd1);
        end
        @(negedge clk);
        chk("basic_after_tvalid", tvalid, 64'd0);
        chk("basic_after_ready", cmd_ready, 64'd1);
        chk("basic_after_busy", busy, 64'd0);
        chk("basic_count", count, 64'd1);
        @(posedge clk);
        #1;

        // backpressure 0,1,0,0,1,1
        base = hs_count;
        send_cmd(3, 8'h40, 8'd7, 8'd9, 1'b0);
        tready = 1'b0;
        for (int k = 1; k < 6; k++) begin
            @(posedge clk);
            #1 tready = ((k == 1) || (k == 4) || (k == 5));
        end
        @(posedge clk);
        #1 tready = 1'b1;
        wait_idle();
        chk("bp_handshakes", hs_count - base, 64'd3);

        // bad frame with data wrap
        send_cmd(3, 8'hFE, 8'd1, 8'd2, 1'b1);
        wait_idle();
        chk("bad_count", count, 64'd3);

        // zero length then single beat
        send_cmd(0, 8'h00, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk("zero_no_tvalid", tvalid, 64'd0);
        chk("zero_ready", cmd_ready, 64'd1);
        @(posedge clk);
        #1;
        send_cmd(1, 8'h77, 8'd4, 8'd6, 1'b1);
        @(negedge clk);
        chk("single_tlast", {tvalid, tlast}, 64'd3);
        @(posedge clk);
        #1;
        wait_idle();
        chk("single_count", count, 64'd4);

        // randomized frames with random backpressure
        tready_rand = 1'b1;
        for (int n = 0; n < 25; n++) begin
            send_cmd($urandom_range(0, 7), 8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)));
            wait_idle();
        end
        tready_rand = 1'b0;
        @(posedge clk);
        #1 tready = 1'b1;
        wait_idle();

        // reset in the middle of a frame
        base = hs_count;
        send_cmd(8, 8'h20, 8'd8, 8'd8, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (hs_count >= base + 3) break;
        end
        chk("mid_hs_reached", hs_count - base, 64'd3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        exp_count  = 0;
        done_exp   = 1'b0;
        lenerr_exp = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_tvalid", tvalid, 64'd0);
        chk("mid_rst_count", count, 64'd0);
        chk("mid_rst_ready", cmd_ready, 64'd1);
        @(posedge clk);
        #1;
        send_cmd(2, 8'h55, 8'd1, 8'd1, 1'b0);
        wait_idle();
        chk("mid_after_count", count, 64'd1);

        // inter-frame gap on the IFG=3 instance, second command queued
        cmd_len_g   = 16'd2;
        cmd_seed_g  = 8'hA0;
        cmd_valid_g = 1'b1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            v[i] = tvalid_g;
            r[i] = cmd_ready_g;
            l[i] = tlast_g;
            d[i] = tdata_g;
            if (cmd_ready_g && cmd_valid_g) acc++;
            @(posedge clk);
            #1;
            if (acc == 1) begin
                cmd_len_g  = 16'd3;
                cmd_seed_g = 8'hC0;
            end else if (acc == 2) begin
                cmd_valid_g = 1'b0;
            end
        end
        last1  = -1;
        first2 = -1;
        for (int i = 0; i < 30; i++) begin
            if (last1 < 0 && v[i] && l[i]) last1 = i;
            if (first2 < 0 && v[i] && d[i] == 8'hC0) first2 = i;
        end
        chk("gap_first_last_found", {(last1 >= 0), (first2 >= 0)}, 64'd3);
        chk("gap_distance", 32'(first2 - last1), 64'd5);
        if (last1 >= 0 && last1 + 4 < 30) begin
            chk("gap_ready_low", {r[last1 + 1], r[last1 + 2], r[last1 + 3]}, 64'd0);
            chk("gap_ready_accept", r[last1 + 4], 64'd1);
        end
        if (first2 >= 0 && first2 + 2 < 30) begin
            chk("gap_frame2_data", {d[first2 + 1], d[first2 + 2]}, 64'hC1C2);
            chk("gap_frame2_last", {l[first2], l[first2 + 1], l[first2 + 2]}, 64'd1);
        end
        chk("gap_count", count_g, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

AXI-Stream frame transmitter that builds complete frames from a single command and drives them into a downstream AXI-Stream sink, typically the frame FIFO's `s_axis` port. Each command specifies:
- beat count;
- `tid` and `tdest`;
- data seed;
- a bad-frame flag.

The block emits deterministic incrementing data and marks the final beat with `tlast` and `tuser`. It is the source-side counterpart used for traffic generation, loopback and FIFO overflow/drop exercise.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of `tdata`
- `KEEP_WIDTH`, `DATA_WIDTH/8`, width of `tkeep`
- `ID_WIDTH`, 8, width of `tid`
- `DEST_WIDTH`, 8, width of `tdest`
- `USER_WIDTH`, 1, width of `tuser`
- `USER_BAD_FRAME_VALUE`, 1'b1, `tuser` value driven on the last beat of a bad frame
- `LEN_WIDTH`, 16, width of `cmd_len`
- `IFG_CYCLES`, 0, minimum idle cycles after each frame's last handshake

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_len`  in  `LEN_WIDTH`  frame length in beats
- `cmd_id`  in  `ID_WIDTH`  `tid` for the whole frame
- `cmd_dest`  in  `DEST_WIDTH`  `tdest` for the whole frame
- `cmd_seed`  in  `DATA_WIDTH`  data value of beat 0
- `cmd_bad`  in  1  mark frame bad via `tuser` on the last beat
- `m_axis_tdata`  out  `DATA_WIDTH`  beat data
- `m_axis_tkeep`  out  `KEEP_WIDTH`  always all ones
- `m_axis_tvalid`  out  1  beat valid
- `m_axis_tready`  in  1  sink ready
- `m_axis_tlast`  out  1  last beat of frame
- `m_axis_tid`  out  `ID_WIDTH`  frame id
- `m_axis_tdest`  out  `DEST_WIDTH`  frame destination
- `m_axis_tuser`  out  `USER_WIDTH`  bad-frame marker
- `status_busy`  out  1  state != IDLE
- `status_frame_done`  out  1  one-cycle pulse per completed frame
- `status_len_error`  out  1  one-cycle pulse for a zero-length command
- `status_frame_count`  out  32  completed frames, wraps modulo 2^32

## Operation
- FSM states: IDLE, SEND, GAP.
- **IDLE**
  - `cmd_ready`=1.
  - A handshake with `cmd_len`≠0 latches len, id, dest, seed and bad; clears `beat_cnt` to 0; next state is SEND.
  - A handshake with `cmd_len`=0 produces no beats. It pulses `status_len_error` and `status_frame_done` on the next cycle. It does not increment `status_frame_count`. State stays IDLE.
- **SEND**
  - `cmd_ready`=0 and `m_axis_tvalid`=1.
  - `tdata` = seed + `beat_cnt`, truncated to `DATA_WIDTH`; wraps mod 2^DATA_WIDTH.
  - `tlast` = (`beat_cnt` == len−1).
  - `tuser` = `USER_BAD_FRAME_VALUE` when `tlast` && bad, otherwise 0.
  - `tid`/`tdest` hold the latched values.
  - All outputs stay stable while `tvalid` && !`tready` (AXI-Stream rule).
- **Handshake in SEND** (`tvalid` && `tready`)
  - Not last beat: `beat_cnt` += 1.
  - Last beat: pulse `status_frame_done` on the next cycle and increment `status_frame_count`. Next state is GAP if `IFG_CYCLES`>0, otherwise IDLE.
- **GAP**: counts `IFG_CYCLES` cycles with `tvalid`=0 and `cmd_ready`=0, then goes to IDLE.
- Internal arithmetic widths:
  - `beat_cnt` is `LEN_WIDTH` bits.
  - len−1 is computed in `LEN_WIDTH` bits, which is safe because len≥1.
  - The maximum frame is 2^LEN_WIDTH−1 beats.

## Timing
- All outputs are registered.
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE;
  - `m_axis_tvalid`=0, `tlast`=0, `tuser`=0, `tdata`/`tid`/`tdest`=0;
  - `cmd_ready`=1 from the first cycle after reset deasserts;
  - `status_busy`=0, `status_frame_done`=0, `status_len_error`=0, `status_frame_count`=0.
- Latency:
  - Command accepted at edge N drives the first beat with `tvalid` high in cycle N+1.
  - With `tready` held high, a len-L frame occupies cycles N+1..N+L.
  - `status_frame_done` is high in cycle N+L+1.
- Back-to-back throughput with `IFG_CYCLES`=0: the next command is accepted in the cycle after the last handshake, giving one idle cycle between frames (IDLE is always visited).
- Zero-length commands do not stall; `cmd_ready` remains 1.
- Reset mid-frame:
  - `tvalid` is low in the cycle after the reset edge.
  - The partial frame is abandoned without `tlast`; the sink must tolerate or flush it.
  - Counters clear.
- `m_axis_tready` toggling: no beat is skipped or duplicated, and data advances only on handshake.

## Test plan
- **Basic frame.** len=4, seed=0x10, id=3, dest=5, `tready`=1.
  - Beats are 0x10, 0x11, 0x12, 0x13 with `tlast` on the 4th beat only.
  - `tid`=3 and `tdest`=5 on every beat.
  - `status_frame_done` pulses once; `status_frame_count`=1.
- **Backpressure.** len=3; `tready` follows the pattern 0, 1, 0, 0, 1, 1.
  - Each beat holds stable while stalled.
  - Exactly 3 handshakes occur, with data 0..2 relative to seed.
- **Bad frame plus wrap.** len=3, seed=0xFE, bad=1.
  - Data is 0xFE, 0xFF, 0x00.
  - `tuser`=0, 0, 1; `tlast` on the 3rd beat.
- **Zero length and single beat.**
  - len=0: no `tvalid`; `status_len_error` and `status_frame_done` pulse; count unchanged.
  - Then len=1: a single beat with `tlast`=1.
- **Inter-frame gap.** `IFG_CYCLES`=3, two queued commands, `tready`=1.
  - `cmd_ready` stays low for 3 GAP cycles plus the IDLE-accept cycle.
  - The second frame's first beat appears 5 cycles after the first frame's last handshake.
- **Reset mid-frame.** len=8; assert `rst_n`=0 after 3 handshakes.
  - `tvalid`=0 in the next cycle and `status_frame_count`=0.
  - A fresh len=2 command afterwards completes normally.
